loop_over_all_nibbles: RTL and testbench
========================================

# loop_over_all_nibbles

Nibble-serial 32-bit adder used as the core ALU of the multi-cycle RV32 control unit, alongside the `instr_stencil` decoder. It adds a 32-bit first operand and a 4·(N+1)-bit second operand, one nibble per clock, with optional sign extension of the second operand. It is used for PC increment, `addi`, and load/store address calculation. Iteration stops early once no carry or sign extension is left to propagate, and untouched upper nibbles keep a caller-supplied preload value.

## Interface
- No parameters; width fixed at 32 bits (8 nibbles).
- Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `loop_perm_to_count` input 1: permission to run; high requests and holds an operation.
- `ctrl` input `AluCtrl`: `carry_in` (initial carry) and `subtract` (invert word2 and its extension).
- `loop_nibbles_number` input 3: N, index of the last explicit word2 nibble (0 = 4 bits … 7 = 32 bits).
- `word2_is_negative` input 1: nibbles above N of word2 read as 0xF, otherwise 0x0.
- `word1` input 32: operand A; all nibbles used.
- `word2` input 32: operand B; nibbles 0..N used.
- `preinit_result` input 32: value loaded into the result register while idle.
- `result` output 32: combinational sum view.
- `busy` output 1: combinational; high while more nibbles remain.

## Operation
- **Idle** (`loop_perm_to_count`=0): at each edge `res_reg`←`preinit_result`, `idx`←0, `carry`←`ctrl.carry_in`. `busy`=0 and `result`=`res_reg`.
- **Active** (`loop_perm_to_count`=1), per cycle at nibble `idx`:
  - A = `word1[idx]`.
  - B = `word2[idx]` if `idx`≤N, else 0xF if `word2_is_negative` else 0x0.
  - If `ctrl.subtract`, B = ~B.
  - {cout, s} = A + B + `carry`.
- `result` = `res_reg` with nibble `idx` replaced by s, so the final sum is visible in the same cycle.
- `final` = (`idx`==7) or (`idx`≥N and cout==0 and the extension nibble is 0x0).
- `busy` = `loop_perm_to_count` and not `final`.
- At each active edge: `res_reg[idx]`←s, `carry`←cout. If not `final`, `idx`++. If `final`, go to Done.
- **Done**: `result` holds `res_reg` and `busy`=0 while `loop_perm_to_count` stays high. No restart happens until `loop_perm_to_count` has been low for at least one edge.
- Nibbles above the last processed one keep their `preinit_result` value.
  - Callers needing word1's upper bits must either preload them (`preinit_result`=`word1`) or guarantee that no carry or sign extension reaches them.
  - Carry out of nibble 7 is discarded (wraps mod 2^32).
- Dropping `loop_perm_to_count` mid-operation aborts: the next edge is Idle behaviour.

## Timing
- Reset: `res_reg`=0, `idx`=0, `carry`=0, Done cleared; `result`=0 and `busy`=0.
- Latency is k cycles, where k = processed nibble count, 1..8. `busy` is high for k−1 cycles and falls in the cycle of the final nibble.
- A controller that advances on `!busy` samples the correct `result` at that same edge. `result` stays valid for one further cycle after `loop_perm_to_count` falls.
- Inputs must be stable while active. `preinit_result` is sampled only while idle.

## Structure
- Shared package holds:
  - the `AluCtrl` struct {`carry_in`, `subtract`};
  - the nibble-count constants INCREMENT=0, BITS_8=1, BITS_12=2, BITS_16=3, BITS_32=7.
- One natural sub-module: `nibble_adder` (4-bit adder with carry in/out).
- `instr_stencil` (instruction field and immediate decode) is a separate combinational block and is not part of this one.

## Test plan
- PC increment: preinit=`word1`=0x000000FF, `word2`=4, N=0, unsigned, run → 3 cycles; `busy` 1,1,0; `result`=0x00000103.
- addi, 12-bit: `word1`=123, `word2`=2, N=2, preinit 0 → `result`=125 after 3 cycles.
- Negative immediate: `word1`=0x7B, `word2`=0xFFE, N=2, negative, preinit 0 → 8 cycles; `result`=0x00000079.
- addi −2048: `word1`=0, `word2`=0x800, N=2, negative → `result`=0xFFFFF800.
- Abort and reset: drop `loop_perm_to_count` after 1 cycle, then rerun; the new result is correct. Assert `rst_n`=0 mid-op → `result`=0 and `busy`=0 immediately.
- Subtract: `word1`=10, `word2`=3, N=7, `subtract`=1, `carry_in`=1 → `result`=7 after 8 cycles.

Source files
------------

// File: rtl/loop_over_all_nibbles_pkg.sv
// Shared types and constants for the nibble-serial adder.
package loop_over_all_nibbles_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned NIB_CNT = 8;
  localparam int unsigned IDX_W   = 3;

  localparam logic [IDX_W-1:0] INCREMENT = 3'd0;
  localparam logic [IDX_W-1:0] BITS_8    = 3'd1;
  localparam logic [IDX_W-1:0] BITS_12   = 3'd2;
  localparam logic [IDX_W-1:0] BITS_16   = 3'd3;
  localparam logic [IDX_W-1:0] BITS_32   = 3'd7;

  typedef struct packed {
    logic carry_in;
    logic subtract;
  } AluCtrl;

  typedef enum logic {
    ST_READY = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

  // Effective word2 nibble above N, after optional inversion for subtract.
  function automatic logic [NIB_W-1:0] ext_nibble(input logic negative, input logic subtract);
    return {NIB_W{negative ^ subtract}};
  endfunction

endpackage

// File: rtl/loop_over_all_nibbles_nibble_adder.sv
// 4-bit adder with carry in/out.
module nibble_adder
  import loop_over_all_nibbles_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);

endmodule

// File: rtl/loop_over_all_nibbles.sv
// Nibble-serial 32-bit adder with sign extension and early termination.
module loop_over_all_nibbles
  import loop_over_all_nibbles_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              loop_perm_to_count,
  input  AluCtrl            ctrl,
  input  logic [IDX_W-1:0]  loop_nibbles_number,
  input  logic              word2_is_negative,
  input  logic [WORD_W-1:0] word1,
  input  logic [WORD_W-1:0] word2,
  input  logic [WORD_W-1:0] preinit_result,
  output logic [WORD_W-1:0] result,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  res_q, res_d, res_upd;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;

  logic [NIB_W-1:0]   a_nib, b_raw, b_nib, sum_nib, ext_nib;
  logic               cout;
  logic               last_nib;
  logic               active;

  // Operand selection for the current nibble.
  always_comb begin
    ext_nib = ext_nibble(word2_is_negative, ctrl.subtract);
    a_nib   = word1[{idx_q, 2'b00} +: NIB_W];
    b_raw   = (idx_q <= loop_nibbles_number) ? word2[{idx_q, 2'b00} +: NIB_W]
                                             : {NIB_W{word2_is_negative}};
    b_nib   = ctrl.subtract ? ~b_raw : b_raw;
  end

  nibble_adder u_nibble_adder (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (sum_nib),
    .cout (cout)
  );

  // Stop once nothing more can propagate into higher nibbles.
  always_comb begin
    last_nib = (idx_q == 3'd7) ||
               ((idx_q >= loop_nibbles_number) && !cout && (ext_nib == 4'h0));
    active   = loop_perm_to_count && rst_n && (state_q == ST_READY);
    busy     = active && !last_nib;
    res_upd  = res_q;
    res_upd[{idx_q, 2'b00} +: NIB_W] = sum_nib;
    result   = active ? res_upd : res_q;
  end

  // Next-state: idle preload, active nibble step, done hold.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    if (!loop_perm_to_count) begin
      state_d = ST_READY;
      res_d   = preinit_result;
      idx_d   = '0;
      carry_d = ctrl.carry_in;
    end else if (state_q == ST_READY) begin
      res_d   = res_upd;
      carry_d = cout;
      if (last_nib) state_d = ST_DONE;
      else          idx_d   = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_READY;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_loop_over_all_nibbles.sv
// Scoreboard bench for the nibble-serial adder: directed vectors, decoupled monitor.
module tb_loop_over_all_nibbles;
  import loop_over_all_nibbles_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        perm;
  AluCtrl      ctrl;
  logic [2:0]  nnum;
  logic        neg;
  logic [31:0] w1, w2, pre;
  logic [31:0] result;
  logic        busy;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  bit   mon_done = 1'b0;

  loop_over_all_nibbles dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .loop_perm_to_count  (perm),
    .ctrl                (ctrl),
    .loop_nibbles_number (nnum),
    .word2_is_negative   (neg),
    .word1               (w1),
    .word2               (w2),
    .preinit_result      (pre),
    .result              (result),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: first !busy cycle while permitted is the output event.
  always @(negedge clk) begin
    if (!rst_n || !perm) begin
      cyc      = 0;
      mon_done = 1'b0;
    end else if (!mon_done) begin
      cyc++;
      if (!busy) begin
        mon_done = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.name, "_result"}, result, e.res);
          check({e.name, "_latency"}, 32'(cyc), 32'(e.lat));
        end
      end
    end
  end

  task automatic setup(input logic [31:0] a, input logic [31:0] b, input logic [2:0] n,
                       input logic ng, input logic sub, input logic cin, input logic [31:0] p);
    @(posedge clk); #1;
    perm = 1'b0; w1 = a; w2 = b; nnum = n; neg = ng;
    ctrl.subtract = sub; ctrl.carry_in = cin; pre = p;
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] n, input logic ng, input logic sub, input logic cin,
                         input logic [31:0] p, input logic [31:0] req, input int lat);
    exp_t e;
    setup(a, b, n, ng, sub, cin, p);
    e.name = name; e.res = req; e.lat = lat;
    exp_q.push_back(e);
    perm = 1'b1;
    for (int i = 0; i < 20 && !mon_done; i++) @(posedge clk);
    if (!mon_done) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    #1;
    @(negedge clk);
    check({name, "_hold_busy"}, 32'(busy), 32'd0);
    check({name, "_hold_result"}, result, req);
    @(posedge clk); #1;
    perm = 1'b0;
    @(negedge clk);
    check({name, "_after_drop"}, result, req);
  endtask

  initial begin
    rst_n = 1'b0; perm = 1'b0; ctrl = '0; nnum = '0; neg = 1'b0;
    w1 = '0; w2 = '0; pre = '0;
    #12;
    check("reset_result", result, 32'h0);
    check("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    run_vec("pc_inc",   32'h0000_00FF, 32'h4,     INCREMENT, 1'b0, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0103, 3);
    run_vec("addi12",   32'd123,       32'd2,     BITS_12,   1'b0, 1'b0, 1'b0, 32'h0,         32'd125,       3);
    run_vec("neg_imm",  32'h0000_007B, 32'hFFE,   BITS_12,   1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0079, 8);
    run_vec("addi_m2k", 32'h0,         32'h800,   BITS_12,   1'b1, 1'b0, 1'b0, 32'h0,         32'hFFFF_F800, 8);
    // Untouched upper nibbles keep the preload.
    run_vec("preload",  32'h0000_0011, 32'h22,    BITS_8,    1'b0, 1'b0, 1'b0, 32'hABCD_0000, 32'hABCD_0033, 2);

    // Abort after one cycle, then rerun.
    setup(32'h0000_00FF, 32'h4, INCREMENT, 1'b0, 1'b0, 1'b0, 32'h0000_00FF);
    perm = 1'b1;
    @(posedge clk); #1;
    perm = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("abort_preload", result, 32'h0000_00FF);
    run_vec("rerun",    32'h0000_00FF, 32'h4,     INCREMENT, 1'b0, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0103, 3);

    // Reset mid-operation.
    setup(32'h0, 32'h800, BITS_12, 1'b1, 1'b0, 1'b0, 32'h0);
    perm = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_result", result, 32'h0);
    check("midrst_busy", 32'(busy), 32'd0);
    perm = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_vec("subtract", 32'd10,        32'd3,     BITS_32,   1'b0, 1'b1, 1'b1, 32'h0,         32'd7,         8);

    if (exp_q.size() != 0) check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
